// File: rtl/fastinput_frame_tx.sv
// fastinput_frame_tx: snapshots four channel counts on start and streams a 19-byte frame through the UART TX byte handshake
// Ports: clk, rst (async, active-low); start and count0..count3 form the frame request;
// send_en/send_data/tx_done form the UART byte handshake; busy, frame_done and timeout_err report status.
module fastinput_frame_tx #(
  parameter int         TX_TIMEOUT = 100000,
  parameter logic [7:0] HDR_BYTE   = 8'h02,
  parameter logic [7:0] ETX_BYTE   = 8'h03
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] count0,
  input  logic [31:0] count1,
  input  logic [31:0] count2,
  input  logic [31:0] count3,
  output logic        send_en,
  output logic [7:0]  send_data,
  input  logic        tx_done,
  output logic        busy,
  output logic        frame_done,
  output logic        timeout_err
);
  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;
  localparam logic [19:0] TMO = 20'(TX_TIMEOUT);
  state_t state, state_nx;
  logic [4:0] idx;
  logic [19:0] cnt;
  logic [31:0] snap [4];
  logic [3:0] k;
  logic [31:0] w, chk_w;
  logic [7:0] chk, frame_byte;
  logic last, expired;
  assign last = idx == 5'd18;
  // cnt holds the number of cycles elapsed since the send_en cycle
  assign expired = cnt == TMO;
  // data bytes 1..16 map to word (idx-1)/4, byte (idx-1)%4 counted from the MSB
  assign k = idx[3:0] - 4'd1;
  assign w = snap[k[3:2]];
  assign chk_w = snap[0] ^ snap[1] ^ snap[2] ^ snap[3];
  assign chk = chk_w[31:24] ^ chk_w[23:16] ^ chk_w[15:8] ^ chk_w[7:0];
  assign frame_byte = idx == 5'd0  ? HDR_BYTE :
                      idx <= 5'd16 ? w[{~k[1:0], 3'b000} +: 8] :
                      idx == 5'd17 ? chk : ETX_BYTE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = start ? SEND : IDLE;
      SEND: state_nx = WAIT;
      WAIT: state_nx = tx_done ? (last ? DONE : SEND) : (expired ? IDLE : WAIT);
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    send_en = state == SEND;
    busy = state == SEND || state == WAIT;
    frame_done = state == DONE;
    send_data = busy ? frame_byte : 8'h00;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      idx <= '0;
      cnt <= '0;
      snap <= '{default: '0};
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          snap <= '{count0, count1, count2, count3};
          idx <= '0;
          timeout_err <= 1'b0;
        end
        SEND: cnt <= 20'd1;
        WAIT: begin
          cnt <= cnt + 20'd1;
          if (tx_done && !last) idx <= idx + 5'd1;
          if (!tx_done && expired) timeout_err <= 1'b1;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_fastinput_frame_tx.sv
// tb_fastinput_frame_tx: scoreboard bench for fastinput_frame_tx with a UART tx_done model
module tb_fastinput_frame_tx;
  logic clk = 0, rst = 0, start = 0, tx_done = 0;
  logic [31:0] c0 = 0, c1 = 0, c2 = 0, c3 = 0;
  logic send_en, busy, frame_done, timeout_err;
  logic [7:0] send_data;
  int errors = 0, checks = 0;
  int delay = 10, drop_at = -1, n_done = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  fastinput_frame_tx #(.TX_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .start(start),
    .count0(c0), .count1(c1), .count2(c2), .count3(c3),
    .send_en(send_en), .send_data(send_data), .tx_done(tx_done),
    .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_frame(input logic [31:0] a, b, c, d);
    logic [31:0] wd [4];
    logic [7:0] by [19];
    logic [7:0] x;
    wd = '{a, b, c, d};
    by[0] = 8'h02;
    for (int i = 0; i < 16; i++) by[i+1] = 8'(wd[i/4] >> (8 * (3 - i % 4)));
    x = 8'h00;
    for (int i = 1; i <= 16; i++) x ^= by[i];
    by[17] = x;
    by[18] = 8'h03;
    for (int i = 0; i < 19; i++) exp_q.push_back(by[i]);
  endtask

  task automatic do_start(input logic [31:0] a, b, c, d);
    @(negedge clk);
    c0 = a; c1 = b; c2 = c; c3 = d;
    start = 1;
    push_frame(a, b, c, d);
    @(negedge clk);
    start = 0;
    chk("busy_after_start", busy, 1);
    chk("first_strobe_latency", send_en, 1);
    chk("terr_cleared_by_start", timeout_err, 0);
  endtask

  task automatic wait_strobe(input int n);
    int seen = 0;
    for (int t = 0; t < 5000 && seen < n; t++) begin
      @(negedge clk);
      if (send_en) seen++;
    end
    chk("strobe_reached", seen, n);
  endtask

  task automatic wait_done(input int d0);
    int t = 0;
    while (!frame_done && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("frame_done_seen", frame_done, 1);
    chk("queue_drained", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    chk("frame_done_count", n_done - d0, 1);
    chk("idle_busy", busy, 0);
  endtask

  // UART model: pulses tx_done `delay` cycles after each strobe unless that byte is dropped
  initial begin
    int n, cd;
    n = 0;
    cd = 0;
    forever begin
      @(negedge clk);
      tx_done = 0;
      if (!busy) n = 0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) tx_done = 1;
      end
      if (send_en) begin
        if (n != drop_at) cd = delay;
        n++;
      end
    end
  end

  // monitor: every strobe is compared against the next expected byte
  initial forever begin
    @(negedge clk);
    if (send_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: byte %h with no byte expected at %0t", send_data, $time);
      end else chk("frame_byte", send_data, exp_q.pop_front());
    end
    if (frame_done) begin
      n_done++;
      chk("done_busy_low", busy, 0);
    end
  end

  initial begin
    int d0;
    repeat (2) @(negedge clk);
    chk("rst_send_en", send_en, 0);
    chk("rst_send_data", send_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_timeout_err", timeout_err, 0);
    rst = 1;
    // basic frame from the worked example
    d0 = n_done;
    do_start(32'h11223344, 32'h0, 32'hFFFFFFFF, 32'h000000A5);
    wait_done(d0);
    // inputs change mid-frame, snapshot must be used
    d0 = n_done;
    do_start(32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D);
    wait_strobe(3);
    c0 = 32'h55555555; c1 = 32'hAAAAAAAA; c2 = 32'h0F0F0F0F; c3 = 32'h12345678;
    wait_done(d0);
    // start pulse during WAIT of byte 5 is ignored
    d0 = n_done;
    do_start(32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10);
    wait_strobe(5);
    repeat (2) @(negedge clk);
    c0 = 32'hFFFF0000;
    start = 1;
    @(negedge clk);
    start = 0;
    chk("busy_during_ignored_start", busy, 1);
    wait_done(d0);
    // timeout on byte 7
    drop_at = 7;
    d0 = n_done;
    do_start(32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4, 32'hD1D2D3D4);
    wait_strobe(7);
    repeat (64) @(negedge clk);
    chk("terr_before_limit", timeout_err, 0);
    chk("busy_before_limit", busy, 1);
    @(negedge clk);
    chk("terr_at_limit", timeout_err, 1);
    chk("busy_after_abort", busy, 0);
    chk("no_done_on_abort", frame_done, 0);
    chk("bytes_left_after_abort", exp_q.size(), 11);
    exp_q.delete();
    drop_at = -1;
    repeat (5) @(negedge clk);
    chk("terr_sticky", timeout_err, 1);
    chk("abort_done_count", n_done - d0, 0);
    d0 = n_done;
    do_start(32'h13579BDF, 32'h2468ACE0, 32'h0, 32'h1);
    wait_done(d0);
    // asynchronous reset during byte 10
    do_start(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    wait_strobe(10);
    repeat (3) @(negedge clk);
    #1 rst = 0;
    #1;
    chk("async_send_en", send_en, 0);
    chk("async_send_data", send_data, 0);
    chk("async_busy", busy, 0);
    chk("async_frame_done", frame_done, 0);
    chk("async_timeout_err", timeout_err, 0);
    exp_q.delete();
    repeat (15) @(negedge clk);
    rst = 1;
    d0 = n_done;
    do_start(32'h89ABCDEF, 32'h76543210, 32'hFEDCBA98, 32'h00FF00FF);
    wait_done(d0);
    // tx_done lands on the same cycle the counter reaches the limit
    delay = 64;
    d0 = n_done;
    do_start(32'h0BADF00D, 32'h600DCAFE, 32'h12121212, 32'h34343434);
    wait_strobe(1);
    repeat (64) @(negedge clk);
    chk("coinc_no_strobe_yet", send_en, 0);
    chk("coinc_busy", busy, 1);
    @(negedge clk);
    chk("coinc_next_strobe", send_en, 1);
    chk("coinc_no_error", timeout_err, 0);
    wait_done(d0);
    chk("coinc_terr_end", timeout_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
